// File: rtl/audio_pkg.sv
// Shared definitions for the audio effect stages: frame packing, FSM states
// and per-channel helpers.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAME_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MIX,
    WRITE
  } fx_state_e;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [SAMPLE_W:0]   wide_sample_t;

  // Left channel occupies the upper half of the frame.
  function automatic sample_t left_ch(input logic [FRAME_W-1:0] frame);
    return sample_t'(frame[FRAME_W-1:SAMPLE_W]);
  endfunction

  // Right channel occupies the lower half of the frame.
  function automatic sample_t right_ch(input logic [FRAME_W-1:0] frame);
    return sample_t'(frame[SAMPLE_W-1:0]);
  endfunction

  // Clamp a one-bit-wider sum back to the sample range; overflow is detected
  // by the top two bits disagreeing, and the sign bit picks the rail.
  function automatic sample_t sat_sample(input wide_sample_t s);
    sample_t r;
    if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
      r = s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      r = s[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Single-port synchronous delay buffer: one-cycle read latency, no reset,
// written so that synthesis maps it onto block RAM.
module echo_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // Write when enabled; read data is registered (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_delay.sv
// Feedback echo stage: each output frame is the input plus the output from
// 2**DEPTH_LOG2 frames earlier, attenuated by an arithmetic right shift.
module echo_delay
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned GAIN_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               AUD_ADCLRCK,
  input  logic               enable,
  input  logic [FRAME_W-1:0] audioIn,
  output logic [FRAME_W-1:0] audioOut,
  output logic               frameDone
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic strobe_q, strobe_d;

  fx_state_e state_q, state_d;

  logic [FRAME_W-1:0]    in_reg_q, in_reg_d;
  logic [FRAME_W-1:0]    audio_out_q, audio_out_d;
  logic                  frame_done_q, frame_done_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                  filled_q, filled_d;

  logic               ram_we;
  logic [FRAME_W-1:0] ram_q;

  sample_t      delayed_l, delayed_r;
  sample_t      shifted_l, shifted_r;
  sample_t      in_l, in_r;
  wide_sample_t sum_l, sum_r;
  sample_t      wet_l, wet_r;

  echo_ram #(
    .ADDR_W(DEPTH_LOG2),
    .DATA_W(FRAME_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (wr_ptr_q),
    .wdata(audio_out_q),
    .rdata(ram_q)
  );

  // Synchroniser and registered rising-edge detect on the codec LR clock.
  always_comb begin
    sync1_d  = AUD_ADCLRCK;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    strobe_d = sync2_q & ~sync3_q;
  end

  // Per-channel mix: gate stale RAM until the buffer has been filled once,
  // attenuate, add with one guard bit, then clamp.
  always_comb begin
    in_l      = left_ch(in_reg_q);
    in_r      = right_ch(in_reg_q);
    delayed_l = filled_q ? left_ch(ram_q)  : '0;
    delayed_r = filled_q ? right_ch(ram_q) : '0;
    shifted_l = delayed_l >>> GAIN_SHIFT;
    shifted_r = delayed_r >>> GAIN_SHIFT;
    sum_l     = {in_l[SAMPLE_W-1], in_l} + {shifted_l[SAMPLE_W-1], shifted_l};
    sum_r     = {in_r[SAMPLE_W-1], in_r} + {shifted_r[SAMPLE_W-1], shifted_r};
    wet_l     = sat_sample(sum_l);
    wet_r     = sat_sample(sum_r);
  end

  // Frame sequencer: latch input, read the oldest entry, mix, write back.
  always_comb begin
    state_d      = state_q;
    in_reg_d     = in_reg_q;
    audio_out_d  = audio_out_q;
    frame_done_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    filled_d     = filled_q;
    ram_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe_q) begin
          in_reg_d = audioIn;
          state_d  = READ;
        end
      end
      READ: begin
        state_d = MIX;
      end
      MIX: begin
        audio_out_d  = enable ? {wet_l, wet_r} : in_reg_q;
        frame_done_d = 1'b1;
        state_d      = WRITE;
      end
      WRITE: begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (&wr_ptr_q) begin
          filled_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; RAM contents are deliberately not reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      strobe_q     <= 1'b0;
      state_q      <= IDLE;
      in_reg_q     <= '0;
      audio_out_q  <= '0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      filled_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      in_reg_q     <= in_reg_d;
      audio_out_q  <= audio_out_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      filled_q     <= filled_d;
    end
  end

  assign audioOut  = audio_out_q;
  assign frameDone = frame_done_q;

endmodule

// File: doc/echo_delay.md
# echo_delay

Feedback-echo effect stage on the ADC-to-DAC audio path. It takes the deserialised 32-bit stereo frame from the ADC receiver and produces one echoed frame per audio sample for the effect-select mux that feeds the DAC serialiser. Each output frame is the input frame plus an attenuated copy of the output from `2**DEPTH_LOG2` frames earlier. The delayed frames are held in an on-chip circular buffer.

## Interface
- `DEPTH_LOG2`, default 12: delay length is `2**DEPTH_LOG2` frames (4096 frames ≈ 85 ms at 48 kHz).
- `GAIN_SHIFT`, default 1: the delayed sample is arithmetically right-shifted by this amount before mixing (1 gives ×0.5). The legal range is 1..15.
- `clk` input, 1 bit: 50 MHz system clock, the only clock.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `AUD_ADCLRCK` input, 1 bit: ADC left/right clock from the codec, asynchronous to `clk`.
- `enable` input, 1 bit: 1 selects echo, 0 selects bypass. This input is already debounced.
- `audioIn` input, 32 bits: `[31:16]` is the left channel and `[15:0]` is the right channel, both signed 16-bit. It is stable whenever a strobe occurs.
- `audioOut` output, 32 bits: processed frame in the same packing as `audioIn`.
- `frameDone` output, 1 bit: one-cycle pulse when `audioOut` updates.

## Operation
- **Strobe generation:**
  - `AUD_ADCLRCK` passes through a 2-flop synchroniser, then a rising-edge detector.
  - The edge detector's output is `strobe`, one cycle per frame.
- **State machine:** `IDLE → READ → MIX → WRITE → IDLE`.
  - **IDLE:** wait for `strobe`. On `strobe`, latch `audioIn` into `inReg` and go to READ.
  - **READ:** present `wrPtr` to the RAM read address. The oldest entry sits at `wrPtr`, so the delay is exactly `2**DEPTH_LOG2` frames.
  - **MIX:** RAM data is valid in this cycle.
    - Per channel: `delayed = filled ? ram_q_ch : 0`.
    - Per channel: `sum = sext17(in_ch) + sext17(delayed >>> GAIN_SHIFT)`.
    - Saturate `sum` to the range −32768..32767.
    - When `enable=1`, register the saturated result into `audioOut`. When `enable=0`, register `inReg` into `audioOut`.
    - Pulse `frameDone`.
  - **WRITE:**
    - Write the new `audioOut` value to RAM at `wrPtr`. This gives feedback: the echo decays by `GAIN_SHIFT` on each pass.
    - Increment `wrPtr`, wrapping modulo `2**DEPTH_LOG2`.
    - When `wrPtr` wraps from all-ones to 0, set `filled`. `filled` is sticky until reset.
- **Bypass:** the buffer is still written in bypass (with the unmodified input), so switching to echo immediately plays recent history.
- **Uninitialised RAM:** before `filled`, the delayed term is forced to 0, so uninitialised RAM never reaches the output.
- **Strobe while not IDLE:** the strobe is dropped. This cannot occur at 48 kHz, since a frame lasts about 1041 cycles and processing takes 4.
- **`enable` changing:** `enable` is sampled only in MIX. A change mid-frame takes effect on the current frame if it is seen in MIX.

## Timing
- **Reset values:**
  - `audioOut` = 0, `frameDone` = 0, `wrPtr` = 0, `filled` = 0.
  - FSM = IDLE, synchroniser flops = 0.
  - RAM contents are not reset.
- **Latency:**
  - The `AUD_ADCLRCK` rise registers in the first synchroniser flop at edge 1. `strobe` is asserted after edge 3.
  - `audioOut` and `frameDone` update at the third edge after the `strobe` cycle (IDLE → READ → MIX → register).
- **Throughput:** one frame per 4 cycles maximum.
- **Reset mid-frame:** the FSM returns to IDLE and the in-flight frame is discarded. No RAM write occurs after reset is asserted.
- **Saturation:** saturation is per channel and independent. A clipped left channel never affects the right channel.
- **Wrap:** after frame index `2**DEPTH_LOG2 − 1`, `wrPtr` = 0 and `filled` = 1. The next frame mixes the data from frame 0.

## Structure
- **Shared package `audio_pkg`:**
  - `SAMPLE_W = 16`, `FRAME_W = 32`.
  - FSM state enum `{IDLE, READ, MIX, WRITE}`.
  - Channel-extract and saturate functions. These are reused by the other effect stages.
- **Sub-module `echo_ram`:**
  - Single-port synchronous RAM, `2**DEPTH_LOG2 × 32`.
  - One-cycle read latency, write-enable, no reset.
  - Infers block RAM.

## Test plan
- **Reset and fill:**
  - Stimulus: assert `rst=0` mid-frame, then release. Run 4096 frames of L=R=1000 with `enable=1`.
  - Required: `audioOut` = 0 during reset, then 1000/1000 for the first 4096 frames.
  - Required: frame 4096 (0-based) outputs 1500/1500.
- **Impulse echo decay:**
  - Stimulus: after `filled`, apply one frame of L=16384, R=0, followed by zeros.
  - Required: left output is 16384, then 8192 at +4096 frames, then 4096 at +8192 frames. Right output stays 0.
- **Saturation:**
  - Stimulus: `filled` with stored value 32767, input L=32767, R=−32768 with stored −32768.
  - Required: output L=32767, R=−32768, with no wrap to the opposite sign.
- **Bypass:**
  - Stimulus: `enable=0`, input 0x1234ABCD.
  - Required: `audioOut` = 0x1234ABCD.
  - Required: after switching to `enable=1` 4096 frames later, the output includes 0x1234ABCD's halves shifted by 1.
- **Latency and pulse:**
  - Stimulus: `AUD_ADCLRCK` rising edge.
  - Required: `frameDone` is high for exactly 1 cycle, 5 cycles after the rise, and `audioOut` changes in the same cycle.
  - Required: holding `AUD_ADCLRCK` high gives no further pulses.
- **Asynchronous edge jitter:**
  - Stimulus: `AUD_ADCLRCK` toggling at 48 kHz with random phase relative to `clk`.
  - Required: exactly one `frameDone` per rising edge.
  - Required: `wrPtr` advances by 1 per frame and wraps at 4096.
